// File: rtl/mac_pipe_acc.sv
// Purpose : 2-stage pipelined unsigned multiplier with per-sample MADD (A*B+C) or frame-accumulate mode.
// Latency : a sample taken on edge k has its result registered on edge k+1 (visible the cycle after).
// Backpressure: none. Accepts one sample per cycle and emits every result as a one-cycle out_valid pulse.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid, mode     sample qualifier; 0 = MADD, 1 = ACC (C ignored)
//   A, B, C            unsigned operands, WIDTH_IN bits
//   DATA_OUT, ovf      result and overflow flag, qualified by out_valid
//   out_valid          one-cycle pulse per result
//   busy, acc_cnt      frame partially filled / products collected in the open frame
module mac_pipe_acc #(
   parameter int unsigned WIDTH_IN  = 8,
   parameter int unsigned WIDTH_OUT = 20,
   parameter int unsigned ACC_LEN   = 4,
   parameter int unsigned SATURATE  = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   input  logic                             mode,
   input  logic [WIDTH_IN-1:0]              A,
   input  logic [WIDTH_IN-1:0]              B,
   input  logic [WIDTH_IN-1:0]              C,
   output logic [WIDTH_OUT-1:0]             DATA_OUT,
   output logic                             out_valid,
   output logic                             ovf,
   output logic                             busy,
   output logic [$clog2(ACC_LEN+1)-1:0]     acc_cnt
);

   localparam int unsigned PW = 2 * WIDTH_IN;      // product width
   localparam int unsigned SW = WIDTH_OUT + 1;     // sum width incl. carry
   localparam int unsigned CW = $clog2(ACC_LEN + 1);

   if (WIDTH_OUT < 2 * WIDTH_IN + 1) begin : g_width_chk
      $error("mac_pipe_acc: WIDTH_OUT must be >= 2*WIDTH_IN+1");
   end
   if (ACC_LEN < 1) begin : g_len_chk
      $error("mac_pipe_acc: ACC_LEN must be >= 1");
   end

   // Stage-1 registers
   logic [PW-1:0]       p1;
   logic [WIDTH_IN-1:0] c1;
   logic                m1;
   logic                v1;

   // Accumulator state
   logic [WIDTH_OUT-1:0] acc;
   logic                 ovf_s;

   // Stage-2 combinational results
   logic [SW-1:0]        madd_sum;
   logic [SW-1:0]        acc_sum;
   logic [WIDTH_OUT-1:0] madd_res;
   logic [WIDTH_OUT-1:0] acc_w;
   logic                 ovf_s_nxt;
   logic                 frame_done;

   always_comb begin
      madd_sum  = SW'(p1) + SW'(c1);
      acc_sum   = {1'b0, acc} + SW'(p1);
      madd_res  = madd_sum[WIDTH_OUT-1:0];
      acc_w     = acc_sum[WIDTH_OUT-1:0];
      // A saturated accumulator is all-ones, so any further nonzero product
      // carries again and re-clamps: the frame stays pinned at all-ones.
      if (SATURATE != 0) begin
         if (madd_sum[WIDTH_OUT]) madd_res = '1;
         if (acc_sum[WIDTH_OUT])  acc_w    = '1;
      end
      ovf_s_nxt  = ovf_s | acc_sum[WIDTH_OUT];
      frame_done = (acc_cnt == CW'(ACC_LEN - 1));
   end

   // Stage 1: register product and side-band
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1 <= '0;
         c1 <= '0;
         m1 <= 1'b0;
         v1 <= 1'b0;
      end else begin
         v1 <= in_valid;
         if (in_valid) begin
            p1 <= PW'(A) * PW'(B);
            c1 <= C;
            m1 <= mode;
         end
      end
   end

   // Stage 2: output register and accumulator. MADD samples leave the open
   // frame untouched so they may be interleaved with ACC samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         DATA_OUT  <= '0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
         busy      <= 1'b0;
         acc_cnt   <= '0;
         acc       <= '0;
         ovf_s     <= 1'b0;
      end else if (v1) begin
         if (!m1) begin
            DATA_OUT  <= madd_res;
            ovf       <= madd_sum[WIDTH_OUT];
            out_valid <= 1'b1;
         end else if (frame_done) begin
            DATA_OUT  <= acc_w;
            ovf       <= ovf_s_nxt;
            out_valid <= 1'b1;
            acc       <= '0;
            acc_cnt   <= '0;
            ovf_s     <= 1'b0;
            busy      <= 1'b0;
         end else begin
            acc       <= acc_w;
            acc_cnt   <= acc_cnt + CW'(1);
            ovf_s     <= ovf_s_nxt;
            out_valid <= 1'b0;
            busy      <= 1'b1;
         end
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mac_pipe_acc.sv
module tb_mac_pipe_acc;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       mode;
   logic [7:0] a, b, c;

   // Default instance: WIDTH_OUT=20, ACC_LEN=4, saturating
   logic [19:0] d20;
   logic        v20, o20, b20;
   logic [2:0]  n20;
   // WIDTH_OUT=17 saturating / wrapping
   logic [16:0] d17s, d17w;
   logic        v17s, o17s, b17s, v17w, o17w, b17w;
   logic [2:0]  n17s, n17w;
   // ACC_LEN=1
   logic [19:0] dl1;
   logic        vl1, ol1, bl1;
   logic [0:0]  nl1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mac_pipe_acc #(.WIDTH_IN(8), .WIDTH_OUT(20), .ACC_LEN(4), .SATURATE(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .A(a), .B(b), .C(c),
      .DATA_OUT(d20), .out_valid(v20), .ovf(o20), .busy(b20), .acc_cnt(n20));
   mac_pipe_acc #(.WIDTH_IN(8), .WIDTH_OUT(17), .ACC_LEN(4), .SATURATE(1)) dut17s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .A(a), .B(b), .C(c),
      .DATA_OUT(d17s), .out_valid(v17s), .ovf(o17s), .busy(b17s), .acc_cnt(n17s));
   mac_pipe_acc #(.WIDTH_IN(8), .WIDTH_OUT(17), .ACC_LEN(4), .SATURATE(0)) dut17w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .A(a), .B(b), .C(c),
      .DATA_OUT(d17w), .out_valid(v17w), .ovf(o17w), .busy(b17w), .acc_cnt(n17w));
   mac_pipe_acc #(.WIDTH_IN(8), .WIDTH_OUT(20), .ACC_LEN(1), .SATURATE(1)) dutl1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .A(a), .B(b), .C(c),
      .DATA_OUT(dl1), .out_valid(vl1), .ovf(ol1), .busy(bl1), .acc_cnt(nl1));

   // Present one input vector, let the next rising edge take it, return 1 ns after.
   task automatic step(input logic v, input logic m, input logic [7:0] aa,
                       input logic [7:0] bb, input logic [7:0] cc);
      in_valid = v; mode = m; a = aa; b = bb; c = cc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
   endtask

   task automatic test_reset();
      rst_n = 1'b1; in_valid = 1'b0; mode = 1'b0; a = 0; b = 0; c = 0;
      #1 rst_n = 1'b0;
      #1;
      tests++;
      if ({d20, v20, o20, b20, n20} !== 26'd0) begin
         fails++; $display("FAIL reset_init: got %h want 0", {d20, v20, o20, b20, n20});
      end
      idle(); idle();
      rst_n = 1'b1;
      // Reset mid-run, between edges, with a second sample still in flight
      step(1'b1, 1'b0, 8'd3, 8'd4, 8'd5);
      step(1'b1, 1'b0, 8'd6, 8'd7, 8'd8);
      tests++;
      if (v20 !== 1'b1 || d20 !== 20'd17) begin
         fails++; $display("FAIL pre_reset_result: got v=%0b d=%0d want v=1 d=17", v20, d20);
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({d20, v20, o20, b20, n20} !== 26'd0) begin
         fails++; $display("FAIL reset_async: got %h want 0", {d20, v20, o20, b20, n20});
      end
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle();
         tests++;
         if (v20 !== 1'b0) begin
            fails++; $display("FAIL reset_discard cyc%0d: got out_valid=%0b want 0", i, v20);
         end
      end
      step(1'b1, 1'b0, 8'd2, 8'd2, 8'd2);
      idle();
      tests++;
      if (v20 !== 1'b1 || d20 !== 20'd6) begin
         fails++; $display("FAIL post_reset_first: got v=%0b d=%0d want v=1 d=6", v20, d20);
      end
      idle();
   endtask

   task automatic test_madd();
      step(1'b1, 1'b0, 8'd200, 8'd150, 8'd255);
      tests++;
      if (v20 !== 1'b0) begin
         fails++; $display("FAIL madd_early: got out_valid=%0b want 0", v20);
      end
      idle();
      tests++;
      if (v20 !== 1'b1 || d20 !== 20'd30255 || o20 !== 1'b0) begin
         fails++; $display("FAIL madd_result: got v=%0b d=%0d ovf=%0b want v=1 d=30255 ovf=0", v20, d20, o20);
      end
      idle();
      tests++;
      if (v20 !== 1'b0 || d20 !== 20'd30255) begin
         fails++; $display("FAIL madd_pulse: got v=%0b d=%0d want v=0 d=30255 (held)", v20, d20);
      end
   endtask

   task automatic test_back_to_back();
      step(1'b1, 1'b0, 8'd1, 8'd1, 8'd0);
      step(1'b1, 1'b0, 8'd2, 8'd3, 8'd4);
      tests++;
      if (v20 !== 1'b1 || d20 !== 20'd1) begin
         fails++; $display("FAIL b2b_0: got v=%0b d=%0d want v=1 d=1", v20, d20);
      end
      step(1'b1, 1'b0, 8'd255, 8'd255, 8'd255);
      tests++;
      if (v20 !== 1'b1 || d20 !== 20'd10) begin
         fails++; $display("FAIL b2b_1: got v=%0b d=%0d want v=1 d=10", v20, d20);
      end
      idle();
      tests++;
      if (v20 !== 1'b1 || d20 !== 20'd65280 || o20 !== 1'b0) begin
         fails++; $display("FAIL b2b_2: got v=%0b d=%0d ovf=%0b want v=1 d=65280 ovf=0", v20, d20, o20);
      end
      tests++;
      if (v17s !== 1'b1 || d17s !== 17'd65280 || o17s !== 1'b0) begin
         fails++; $display("FAIL madd_w17: got v=%0b d=%0d ovf=%0b want v=1 d=65280 ovf=0", v17s, d17s, o17s);
      end
      idle();
      tests++;
      if (v20 !== 1'b0) begin
         fails++; $display("FAIL b2b_end: got out_valid=%0b want 0", v20);
      end
   endtask

   task automatic test_acc_frame();
      step(1'b1, 1'b1, 8'd255, 8'd255, 8'd0);
      step(1'b1, 1'b1, 8'd255, 8'd255, 8'd0);
      tests++;
      if (n20 !== 3'd1 || b20 !== 1'b1 || v20 !== 1'b0) begin
         fails++; $display("FAIL acc_cnt1: got cnt=%0d busy=%0b v=%0b want 1 1 0", n20, b20, v20);
      end
      tests++;
      if (vl1 !== 1'b1 || dl1 !== 20'd65025 || bl1 !== 1'b0 || nl1 !== 1'b0) begin
         fails++; $display("FAIL acc_len1: got v=%0b d=%0d busy=%0b cnt=%0d want 1 65025 0 0", vl1, dl1, bl1, nl1);
      end
      idle();
      tests++;
      if (n20 !== 3'd2 || b20 !== 1'b1) begin
         fails++; $display("FAIL acc_cnt2: got cnt=%0d busy=%0b want 2 1", n20, b20);
      end
      step(1'b1, 1'b1, 8'd255, 8'd255, 8'd0);
      tests++;
      if (n20 !== 3'd2 || v20 !== 1'b0) begin
         fails++; $display("FAIL acc_gap_hold: got cnt=%0d v=%0b want 2 0", n20, v20);
      end
      step(1'b1, 1'b1, 8'd255, 8'd255, 8'd0);
      tests++;
      if (n20 !== 3'd3 || b20 !== 1'b1 || v20 !== 1'b0) begin
         fails++; $display("FAIL acc_cnt3: got cnt=%0d busy=%0b v=%0b want 3 1 0", n20, b20, v20);
      end
      idle();
      tests++;
      if (v20 !== 1'b1 || d20 !== 20'd260100 || o20 !== 1'b0 || n20 !== 3'd0 || b20 !== 1'b0) begin
         fails++; $display("FAIL acc_frame: got v=%0b d=%0d ovf=%0b cnt=%0d busy=%0b want 1 260100 0 0 0", v20, d20, o20, n20, b20);
      end
      tests++;
      if (v17s !== 1'b1 || d17s !== 17'd131071 || o17s !== 1'b1) begin
         fails++; $display("FAIL acc_sat17: got v=%0b d=%0d ovf=%0b want 1 131071 1", v17s, d17s, o17s);
      end
      tests++;
      if (v17w !== 1'b1 || d17w !== 17'd129028 || o17w !== 1'b1) begin
         fails++; $display("FAIL acc_wrap17: got v=%0b d=%0d ovf=%0b want 1 129028 1", v17w, d17w, o17w);
      end
      idle();
      tests++;
      if (v20 !== 1'b0) begin
         fails++; $display("FAIL acc_single_pulse: got out_valid=%0b want 0", v20);
      end
   endtask

   task automatic test_ovf_clear();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'd1, 8'd1, 8'd0);
      idle();
      tests++;
      if (v17s !== 1'b1 || d17s !== 17'd4 || o17s !== 1'b0) begin
         fails++; $display("FAIL ovf_clear_sat: got v=%0b d=%0d ovf=%0b want 1 4 0", v17s, d17s, o17s);
      end
      tests++;
      if (v17w !== 1'b1 || d17w !== 17'd4 || o17w !== 1'b0) begin
         fails++; $display("FAIL ovf_clear_wrap: got v=%0b d=%0d ovf=%0b want 1 4 0", v17w, d17w, o17w);
      end
      idle();
   endtask

   task automatic test_interleave();
      step(1'b1, 1'b1, 8'd2, 8'd2, 8'd0);
      step(1'b1, 1'b1, 8'd3, 8'd3, 8'd0);
      step(1'b1, 1'b0, 8'd10, 8'd10, 8'd5);
      tests++;
      if (n20 !== 3'd2 || v20 !== 1'b0) begin
         fails++; $display("FAIL ilv_pre: got cnt=%0d v=%0b want 2 0", n20, v20);
      end
      step(1'b1, 1'b1, 8'd1, 8'd1, 8'd0);
      tests++;
      if (v20 !== 1'b1 || d20 !== 20'd105 || n20 !== 3'd2 || b20 !== 1'b1) begin
         fails++; $display("FAIL ilv_madd: got v=%0b d=%0d cnt=%0d busy=%0b want 1 105 2 1", v20, d20, n20, b20);
      end
      step(1'b1, 1'b1, 8'd4, 8'd4, 8'd0);
      tests++;
      if (v20 !== 1'b0 || n20 !== 3'd3) begin
         fails++; $display("FAIL ilv_cnt3: got v=%0b cnt=%0d want 0 3", v20, n20);
      end
      idle();
      tests++;
      if (v20 !== 1'b1 || d20 !== 20'd30 || o20 !== 1'b0 || n20 !== 3'd0) begin
         fails++; $display("FAIL ilv_frame: got v=%0b d=%0d ovf=%0b cnt=%0d want 1 30 0 0", v20, d20, o20, n20);
      end
      idle();
   endtask

   task automatic test_reset_mid_frame();
      step(1'b1, 1'b1, 8'd1, 8'd1, 8'd0);
      step(1'b1, 1'b1, 8'd1, 8'd1, 8'd0);
      idle();
      tests++;
      if (n20 !== 3'd2) begin
         fails++; $display("FAIL rmf_pre: got cnt=%0d want 2", n20);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (n20 !== 3'd0 || b20 !== 1'b0) begin
         fails++; $display("FAIL rmf_reset: got cnt=%0d busy=%0b want 0 0", n20, b20);
      end
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'd1, 8'd1, 8'd0);
      tests++;
      if (v20 !== 1'b0 || n20 !== 3'd3) begin
         fails++; $display("FAIL rmf_cnt3: got v=%0b cnt=%0d want 0 3", v20, n20);
      end
      idle();
      tests++;
      if (v20 !== 1'b1 || d20 !== 20'd4) begin
         fails++; $display("FAIL rmf_frame: got v=%0b d=%0d want 1 4", v20, d20);
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_madd();
      test_back_to_back();
      test_acc_frame();
      test_ovf_clear();
      test_interleave();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
